// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types for the L1-to-L2 miss arbitration path
package cache_pkg;

    localparam int LINE_W = 256;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/l1_miss_arbiter_if.sv
// rtl/l1_miss_arbiter_if.sv - L1 requester ports and L2 request port bundled for the miss arbiter
interface l1_miss_arbiter_if;
    import cache_pkg::*;

    logic        pmem_read_a;
    logic [31:0] pmem_addr_a;
    logic        pmem_resp_a;
    line_t       pmem_rdata_a;

    logic        pmem_read_b;
    logic        pmem_write_b;
    logic [31:0] pmem_addr_b;
    line_t       pmem_wdata_b;
    logic        pmem_resp_b;
    line_t       pmem_rdata_b;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    line_t       mem_wdata;
    line_t       mem_rdata;
    logic        mem_resp;

    modport slave (
        input  pmem_read_a, pmem_addr_a,
        input  pmem_read_b, pmem_write_b, pmem_addr_b, pmem_wdata_b,
        input  mem_rdata, mem_resp,
        output pmem_resp_a, pmem_rdata_a,
        output pmem_resp_b, pmem_rdata_b,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output pmem_read_a, pmem_addr_a,
        output pmem_read_b, pmem_write_b, pmem_addr_b, pmem_wdata_b,
        output mem_rdata, mem_resp,
        input  pmem_resp_a, pmem_rdata_a,
        input  pmem_resp_b, pmem_rdata_b,
        input  mem_read, mem_write, mem_address, mem_wdata
    );

endinterface

// File: rtl/l1_miss_arbiter.sv
// rtl/l1_miss_arbiter.sv - grants the single L2 port to I-cache (A) or D-cache (B) misses
// D-side wins by default; a starvation counter forces an I-side grant after STARVE_LIMIT B wins.
module l1_miss_arbiter
    import cache_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    l1_miss_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] starve_cnt;

    logic        req_a;
    logic        req_b;
    logic        grant_a;
    logic        grant_b;

    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    line_t       wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        req_a      = bus.pmem_read_a;
        req_b      = bus.pmem_read_b | bus.pmem_write_b;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || starve_cnt == CNT_MAX)) begin
                    grant_a    = 1'b1;
                    state_next = SERVE_A;
                end else if (req_b) begin
                    grant_b    = 1'b1;
                    state_next = SERVE_B;
                end
            end
            SERVE_A, SERVE_B: begin
                if (bus.mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.pmem_resp_a  = bus.mem_resp && (state == SERVE_A);
        bus.pmem_resp_b  = bus.mem_resp && (state == SERVE_B);
        bus.pmem_rdata_a = bus.mem_rdata;
        bus.pmem_rdata_b = bus.mem_rdata;
        bus.mem_read     = rd_q;
        bus.mem_write    = wr_q;
        bus.mem_address  = addr_q;
        bus.mem_wdata    = wdata_q;
    end

    // Request latch and starvation counter; a simultaneous B read+write is taken as a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
        end else if (grant_a) begin
            rd_q       <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= bus.pmem_addr_a;
            starve_cnt <= '0;
        end else if (grant_b) begin
            rd_q   <= ~bus.pmem_write_b;
            wr_q   <= bus.pmem_write_b;
            addr_q <= bus.pmem_addr_b;
            if (bus.pmem_write_b) begin
                wdata_q <= bus.pmem_wdata_b;
            end
            if (!req_a) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (state != IDLE && bus.mem_resp) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l1_miss_arbiter.sv
// tb/tb_l1_miss_arbiter.sv - directed self-checking bench for l1_miss_arbiter
module tb_l1_miss_arbiter;
    import cache_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    l1_miss_arbiter_if ifc ();

    l1_miss_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && ifc.pmem_read_b && ifc.pmem_write_b)
            $display("note: port B read and write asserted together at %0t, handled as write", $time);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    line_t line_aa, line_55, line_w1, line_w2, line_cc;

    initial begin
        errors = 0;
        checks = 0;
        line_aa = {32{8'hAA}};
        line_55 = {32{8'h55}};
        line_w1 = {8{32'hDEAD_BEEF}};
        line_w2 = {8{32'h1234_5678}};
        line_cc = {32{8'hCC}};

        rst_n            = 1'b0;
        ifc.pmem_read_a  = 1'b0;
        ifc.pmem_addr_a  = '0;
        ifc.pmem_read_b  = 1'b0;
        ifc.pmem_write_b = 1'b0;
        ifc.pmem_addr_b  = '0;
        ifc.pmem_wdata_b = '0;
        ifc.mem_rdata    = '0;
        ifc.mem_resp     = 1'b0;

        tick();
        tick();
        check("rst_state",  256'(dut.state),       256'(IDLE));
        check("rst_cnt",    256'(dut.starve_cnt),  256'(0));
        check("rst_mrd",    256'(ifc.mem_read),    256'(0));
        check("rst_mwr",    256'(ifc.mem_write),   256'(0));
        check("rst_resp_a", 256'(ifc.pmem_resp_a), 256'(0));
        check("rst_resp_b", 256'(ifc.pmem_resp_b), 256'(0));
        check("rst_addr",   256'(ifc.mem_address), 256'(0));
        check("rst_wdata",  256'(ifc.mem_wdata),   256'(0));

        // Lone A read, L2 answers in the third cycle of the request.
        rst_n = 1'b1;
        ifc.pmem_read_a = 1'b1;
        ifc.pmem_addr_a = 32'h0000_0040;
        tick();
        check("a_state", 256'(dut.state),       256'(SERVE_A));
        check("a_mrd",   256'(ifc.mem_read),    256'(1));
        check("a_mwr",   256'(ifc.mem_write),   256'(0));
        check("a_addr",  256'(ifc.mem_address), 256'(32'h40));
        tick();
        tick();
        ifc.mem_rdata   = line_aa;
        ifc.mem_resp    = 1'b1;
        ifc.pmem_read_a = 1'b0;
        #1;
        check("a_resp_a",  256'(ifc.pmem_resp_a),  256'(1));
        check("a_rdata_a", 256'(ifc.pmem_rdata_a), 256'(line_aa));
        check("a_resp_b",  256'(ifc.pmem_resp_b),  256'(0));
        tick();
        ifc.mem_resp = 1'b0;
        check("a_done_state", 256'(dut.state),    256'(IDLE));
        check("a_done_mrd",   256'(ifc.mem_read), 256'(0));

        // A and B together, counter at 0: B first, A at the edge after B's resp.
        ifc.pmem_read_a = 1'b1;
        ifc.pmem_addr_a = 32'h0000_0080;
        ifc.pmem_read_b = 1'b1;
        ifc.pmem_addr_b = 32'h0000_0100;
        tick();
        check("ab_state_b", 256'(dut.state),       256'(SERVE_B));
        check("ab_addr_b",  256'(ifc.mem_address), 256'(32'h100));
        check("ab_cnt1",    256'(dut.starve_cnt),  256'(1));
        tick();
        ifc.mem_rdata   = line_55;
        ifc.mem_resp    = 1'b1;
        ifc.pmem_read_b = 1'b0;
        #1;
        check("ab_resp_b",  256'(ifc.pmem_resp_b),  256'(1));
        check("ab_resp_a0", 256'(ifc.pmem_resp_a),  256'(0));
        check("ab_rdata_b", 256'(ifc.pmem_rdata_b), 256'(line_55));
        tick();
        ifc.mem_resp = 1'b0;
        check("ab_idle", 256'(dut.state), 256'(IDLE));
        tick();
        check("ab_state_a", 256'(dut.state),       256'(SERVE_A));
        check("ab_addr_a",  256'(ifc.mem_address), 256'(32'h80));
        check("ab_cnt0",    256'(dut.starve_cnt),  256'(0));
        ifc.mem_resp    = 1'b1;
        ifc.pmem_read_a = 1'b0;
        #1;
        check("ab_resp_a", 256'(ifc.pmem_resp_a), 256'(1));
        tick();
        ifc.mem_resp = 1'b0;

        // Sustained B writebacks with A waiting: four B grants then A is forced.
        ifc.pmem_read_a  = 1'b1;
        ifc.pmem_addr_a  = 32'h0000_00C0;
        ifc.pmem_write_b = 1'b1;
        ifc.pmem_addr_b  = 32'h0000_0200;
        ifc.pmem_wdata_b = line_cc;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                check($sformatf("stv_state_%0d", k), 256'(dut.state),      256'(SERVE_B));
                check($sformatf("stv_mwr_%0d", k),   256'(ifc.mem_write),  256'(1));
                check($sformatf("stv_cnt_%0d", k),   256'(dut.starve_cnt), 256'(k + 1));
            end else begin
                check("stv_forced_a", 256'(dut.state),       256'(SERVE_A));
                check("stv_addr_a",   256'(ifc.mem_address), 256'(32'hC0));
                check("stv_cnt_clr",  256'(dut.starve_cnt),  256'(0));
            end
            tick();
            ifc.mem_resp = 1'b1;
            if (k == 4) begin
                ifc.pmem_read_a  = 1'b0;
                ifc.pmem_write_b = 1'b0;
            end
            #1;
            tick();
            ifc.mem_resp = 1'b0;
        end

        // B writeback whose requester changes address/data after the grant.
        ifc.pmem_write_b = 1'b1;
        ifc.pmem_addr_b  = 32'h0000_1000;
        ifc.pmem_wdata_b = line_w1;
        tick();
        check("wb_mwr",  256'(ifc.mem_write),   256'(1));
        check("wb_mrd",  256'(ifc.mem_read),    256'(0));
        tick();
        ifc.pmem_addr_b  = 32'h0000_2000;
        ifc.pmem_wdata_b = line_w2;
        tick();
        check("wb_addr_hold",  256'(ifc.mem_address), 256'(32'h1000));
        check("wb_wdata_hold", 256'(ifc.mem_wdata),   256'(line_w1));
        ifc.mem_resp     = 1'b1;
        ifc.pmem_write_b = 1'b0;
        #1;
        check("wb_resp_b", 256'(ifc.pmem_resp_b), 256'(1));
        tick();
        ifc.mem_resp = 1'b0;

        // Illegal B read+write together is issued as a write.
        ifc.pmem_read_b  = 1'b1;
        ifc.pmem_write_b = 1'b1;
        ifc.pmem_addr_b  = 32'h0000_0400;
        tick();
        check("ill_mwr", 256'(ifc.mem_write), 256'(1));
        check("ill_mrd", 256'(ifc.mem_read),  256'(0));
        ifc.mem_resp     = 1'b1;
        ifc.pmem_read_b  = 1'b0;
        ifc.pmem_write_b = 1'b0;
        #1;
        tick();
        ifc.mem_resp = 1'b0;

        // Reset in the middle of a B writeback; a late L2 resp is not forwarded.
        ifc.pmem_write_b = 1'b1;
        ifc.pmem_addr_b  = 32'h0000_0300;
        tick();
        check("rmid_state_b", 256'(dut.state), 256'(SERVE_B));
        rst_n            = 1'b0;
        ifc.pmem_write_b = 1'b0;
        tick();
        check("rmid_state", 256'(dut.state),     256'(IDLE));
        check("rmid_mwr",   256'(ifc.mem_write), 256'(0));
        rst_n        = 1'b1;
        ifc.mem_resp = 1'b1;
        #1;
        check("rmid_late_resp_b", 256'(ifc.pmem_resp_b), 256'(0));
        check("rmid_late_resp_a", 256'(ifc.pmem_resp_a), 256'(0));
        tick();
        ifc.mem_resp = 1'b0;
        check("rmid_still_idle", 256'(dut.state), 256'(IDLE));

        // Stray resp pulse in IDLE.
        tick();
        ifc.mem_resp = 1'b1;
        #1;
        check("idle_resp_a", 256'(ifc.pmem_resp_a), 256'(0));
        check("idle_resp_b", 256'(ifc.pmem_resp_b), 256'(0));
        tick();
        ifc.mem_resp = 1'b0;
        check("idle_state", 256'(dut.state),     256'(IDLE));
        check("idle_mrd",   256'(ifc.mem_read),  256'(0));
        check("idle_mwr",   256'(ifc.mem_write), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
